// File: rtl/switch_mem_target_if.sv
// Memory/config port bus between the interface agent (master) and the target (slave).
// Carries one request at a time; the target answers with a one-cycle ack.
interface switch_mem_target_if;
  logic       mem_sel_en;
  logic       mem_wr_rd_s;
  logic [7:0] mem_addr;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;
  logic       mem_ack;

  modport master (
    output mem_sel_en, mem_wr_rd_s, mem_addr, mem_wr_data,
    input  mem_rd_data, mem_ack
  );

  modport slave (
    input  mem_sel_en, mem_wr_rd_s, mem_addr, mem_wr_data,
    output mem_rd_data, mem_ack
  );
endinterface

// File: rtl/switch_mem_target.sv
// Byte-wide config register file behind the switch memory port; ack WAIT_STATES+1 cycles after capture.
// Single outstanding request: new requests are only sampled in IDLE, so spacing is WAIT_STATES+2 cycles.
module switch_mem_target #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  switch_mem_target_if.slave   bus,
  output logic [7:0]           cfg_reg0
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic [7:0] rd_data;
  logic [7:0] mem [DEPTH];

  logic       eff_wr;
  logic [7:0] eff_addr;
  logic [7:0] eff_data;
  logic       addr_ok;
  logic       enter_ack;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.mem_sel_en) state_nx = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
      S_WAIT: if (cnt == 4'd0) state_nx = S_ACK;
      S_ACK:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // With zero wait states ACK is entered at the capture edge, so the live bus is used.
  always_comb begin
    eff_wr    = req_wr;
    eff_addr  = req_addr;
    eff_data  = req_data;
    if (state == S_IDLE) begin
      eff_wr   = bus.mem_wr_rd_s;
      eff_addr = bus.mem_addr;
      eff_data = bus.mem_wr_data;
    end
    addr_ok   = ({1'b0, eff_addr} < 9'(DEPTH));
    enter_ack = (state_nx == S_ACK) && (state != S_ACK);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      req_wr   <= 1'b0;
      req_addr <= 8'h00;
      req_data <= 8'h00;
      rd_data  <= 8'h00;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && bus.mem_sel_en) begin
        req_wr   <= bus.mem_wr_rd_s;
        req_addr <= bus.mem_addr;
        req_data <= bus.mem_wr_data;
        cnt      <= WS_LOAD;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_ack) begin
        if (eff_wr) begin
          if (addr_ok) mem[eff_addr[AW-1:0]] <= eff_data;
        end else begin
          rd_data <= addr_ok ? mem[eff_addr[AW-1:0]] : 8'h00;
        end
      end
    end
  end

  assign bus.mem_ack     = (state == S_ACK);
  assign bus.mem_rd_data = rd_data;
  assign cfg_reg0        = mem[0];

endmodule

// File: tb/tb_switch_mem_target.sv
// Bench for switch_mem_target: default instance (DEPTH=256, 1 wait state) and a DEPTH=16, 0-wait instance.
module tb_switch_mem_target;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  switch_mem_target_if bus0 ();
  switch_mem_target_if bus1 ();
  logic [7:0] cfg0, cfg1;

  switch_mem_target dut0 (.clock(clock), .reset(reset), .bus(bus0.slave), .cfg_reg0(cfg0));
  switch_mem_target #(.DEPTH(16), .WAIT_STATES(0)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1.slave), .cfg_reg0(cfg1));

  typedef struct {
    int         d;
    bit         wr;
    logic [7:0] a;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic [7:0] exp_cfg;
  } vec_t;

  // Reference model: plain per-instance arrays following the register-file rules.
  int         depth   [2] = '{256, 16};
  int         exp_lat [2] = '{2, 1};
  logic [7:0] ref_mem [2][256];
  logic [7:0] ref_rd  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_bus(input int d, input bit sel, input bit wr, input logic [7:0] a,
                         input logic [7:0] wd);
    if (d == 0) begin
      bus0.mem_sel_en = sel; bus0.mem_wr_rd_s = wr; bus0.mem_addr = a; bus0.mem_wr_data = wd;
    end else begin
      bus1.mem_sel_en = sel; bus1.mem_wr_rd_s = wr; bus1.mem_addr = a; bus1.mem_wr_data = wd;
    end
  endtask

  function automatic logic get_ack(input int d);
    return (d == 0) ? bus0.mem_ack : bus1.mem_ack;
  endfunction

  function automatic logic [7:0] get_rd(input int d);
    return (d == 0) ? bus0.mem_rd_data : bus1.mem_rd_data;
  endfunction

  function automatic logic [7:0] get_cfg(input int d);
    return (d == 0) ? cfg0 : cfg1;
  endfunction

  // Latency counts posedges from the capture edge up to the one after which ack is high.
  task automatic txn(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                     output logic [7:0] rd, output logic [7:0] cfg, output int lat);
    @(negedge clock);
    set_bus(d, 1'b1, wr, a, wd);
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    set_bus(d, 1'b0, 1'b0, 8'h00, 8'h00);
    while (!get_ack(d) && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    rd  = get_rd(d);
    cfg = get_cfg(d);
  endtask

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      ref_rd[d] = 8'h00;
      for (int i = 0; i < 256; i++) ref_mem[d][i] = 8'h00;
    end
  endfunction

  initial begin
    vec_t       tbl [$];
    logic [7:0] rd, cfg;
    int         lat;

    set_bus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_bus(1, 1'b0, 1'b0, 8'h00, 8'h00);
    model_clear();

    tbl.push_back('{0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00});
    tbl.push_back('{0, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00});
    tbl.push_back('{0, 1'b0, 8'h02, 8'h00, 8'h00, 8'h00});
    tbl.push_back('{0, 1'b0, 8'h03, 8'h00, 8'h00, 8'h00});
    tbl.push_back('{0, 1'b1, 8'h10, 8'hA5, 8'h00, 8'h00});
    tbl.push_back('{0, 1'b0, 8'h10, 8'h00, 8'hA5, 8'h00});
    tbl.push_back('{0, 1'b1, 8'h00, 8'h3C, 8'hA5, 8'h3C});
    tbl.push_back('{0, 1'b0, 8'h00, 8'h00, 8'h3C, 8'h3C});
    tbl.push_back('{0, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h3C});
    tbl.push_back('{1, 1'b1, 8'h20, 8'h77, 8'h00, 8'h00});
    tbl.push_back('{1, 1'b0, 8'h20, 8'h00, 8'h00, 8'h00});
    tbl.push_back('{1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00});
    tbl.push_back('{1, 1'b0, 8'h0F, 8'h00, 8'h00, 8'h00});
    tbl.push_back('{1, 1'b1, 8'h0F, 8'h5A, 8'h00, 8'h00});
    tbl.push_back('{1, 1'b0, 8'h0F, 8'h00, 8'h5A, 8'h00});
    tbl.push_back('{1, 1'b1, 8'h10, 8'h01, 8'h5A, 8'h00});
    tbl.push_back('{1, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00});

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    chk("reset_ack0", {31'd0, bus0.mem_ack}, 32'd0);
    chk("reset_rd0", {24'd0, bus0.mem_rd_data}, 32'd0);
    chk("reset_cfg0", {24'd0, cfg0}, 32'd0);
    chk("reset_ack1", {31'd0, bus1.mem_ack}, 32'd0);
    chk("reset_cfg1", {24'd0, cfg1}, 32'd0);

    foreach (tbl[i]) begin
      txn(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd, rd, cfg, lat);
      chk($sformatf("tbl%0d_lat", i), lat, exp_lat[tbl[i].d]);
      chk($sformatf("tbl%0d_rd", i), {24'd0, rd}, {24'd0, tbl[i].exp_rd});
      chk($sformatf("tbl%0d_cfg", i), {24'd0, cfg}, {24'd0, tbl[i].exp_cfg});
      @(negedge clock);
      chk($sformatf("tbl%0d_pulse", i), {31'd0, get_ack(tbl[i].d)}, 32'd0);
    end

    // Back-to-back with sel_en held high: write/read/write/read @0x05 on both instances.
    for (int d = 0; d < 2; d++) begin
      bit         ops_wr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [7:0] ops_wd [4] = '{8'h11, 8'h00, 8'h22, 8'h00};
      logic [7:0] ops_rd [4] = '{8'h00, 8'h11, 8'h00, 8'h22};
      int idx = 0;
      int cyc = 0;
      int prev = 0;
      @(negedge clock);
      set_bus(d, 1'b1, ops_wr[0], 8'h05, ops_wd[0]);
      while (idx < 4 && cyc < 60) begin
        @(posedge clock);
        cyc++;
        @(negedge clock);
        if (get_ack(d)) begin
          chk($sformatf("b2b%0d_gap%0d", d, idx), cyc - prev,
              (idx == 0) ? exp_lat[d] : exp_lat[d] + 1);
          if (!ops_wr[idx]) chk($sformatf("b2b%0d_rd%0d", d, idx), {24'd0, get_rd(d)},
                                {24'd0, ops_rd[idx]});
          prev = cyc;
          idx++;
          if (idx < 4) set_bus(d, 1'b1, ops_wr[idx], 8'h05, ops_wd[idx]);
          else set_bus(d, 1'b0, 1'b0, 8'h00, 8'h00);
        end
      end
      chk($sformatf("b2b%0d_done", d), idx, 4);
      set_bus(d, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
    end

    // Reset while the default instance sits in WAIT with a write of 0xFF @0x08.
    begin
      int acks = 0;
      @(negedge clock);
      set_bus(0, 1'b1, 1'b1, 8'h08, 8'hFF);
      @(posedge clock);
      @(negedge clock);
      set_bus(0, 1'b0, 1'b0, 8'h00, 8'h00);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_clear();
      if (bus0.mem_ack) acks++;
      for (int k = 0; k < 5; k++) begin
        @(negedge clock);
        if (bus0.mem_ack) acks++;
      end
      chk("rst_wait_noack", acks, 0);
      txn(0, 1'b0, 8'h08, 8'h00, rd, cfg, lat);
      chk("rst_wait_lat", lat, 2);
      chk("rst_wait_rd", {24'd0, rd}, 32'd0);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      int         d  = int'($urandom_range(0, 1));
      bit         wr = 1'($urandom_range(0, 1));
      logic [7:0] a  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      logic [7:0] wd = 8'($urandom);
      logic [7:0] exp_rd;
      if (wr) begin
        if (int'(a) < depth[d]) ref_mem[d][a] = wd;
      end else begin
        ref_rd[d] = (int'(a) < depth[d]) ? ref_mem[d][a] : 8'h00;
      end
      exp_rd = ref_rd[d];
      txn(d, wr, a, wd, rd, cfg, lat);
      chk($sformatf("rnd%0d_lat", n), lat, exp_lat[d]);
      chk($sformatf("rnd%0d_rd", n), {24'd0, rd}, {24'd0, exp_rd});
      chk($sformatf("rnd%0d_cfg", n), {24'd0, cfg}, {24'd0, ref_mem[d][0]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
